// File: rtl/mod_div_seq.sv
// mod_div_seq: restoring shift-subtract divider, one quotient bit per clock, start/done handshake.
// Define MOD_DIV_SIGNED_EN to add the signed_op port for two's-complement truncating division.
module mod_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
`ifdef MOD_DIV_SIGNED_EN
    input  logic             signed_op,
`endif
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] b_q, rem_q, quo_q, quotient_q, remainder_q;
    logic [CNT_W-1:0] cnt_q;
    logic             q_neg_q, r_neg_q, ready_q, busy_q, done_q, dbz_q;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, rem_d, quo_d;
    logic [WIDTH:0]   diff;
`ifdef MOD_DIV_SIGNED_EN
    assign a_neg = signed_op & A[WIDTH-1];
    assign b_neg = signed_op & B[WIDTH-1];
`else
    assign a_neg = 1'b0;
    assign b_neg = 1'b0;
`endif
    assign a_mag = a_neg ? -A : A;
    assign b_mag = b_neg ? -B : B;
    // A borrow out of the (WIDTH+1)-bit subtraction means the shifted remainder is below the divisor.
    assign diff  = {rem_q, quo_q[WIDTH-1]} - {1'b0, b_q};
    assign rem_d = diff[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : diff[WIDTH-1:0];
    assign quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            b_q         <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            cnt_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start && ready_q) begin
                b_q     <= b_mag;
                rem_q   <= '0;
                quo_q   <= a_mag;
                cnt_q   <= CNT_W'(WIDTH);
                q_neg_q <= a_neg ^ b_neg;
                r_neg_q <= a_neg;
                if (B == '0) begin
                    state_q     <= DONE;
                    quotient_q  <= '1;
                    remainder_q <= A;
                    dbz_q       <= 1'b1;
                    done_q      <= 1'b1;
                end else begin
                    state_q <= CALC;
                    dbz_q   <= 1'b0;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b1;
                end
            end else begin
                case (state_q)
                    CALC: begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            state_q     <= DONE;
                            quotient_q  <= q_neg_q ? -quo_d : quo_d;
                            remainder_q <= r_neg_q ? -rem_d : rem_d;
                            done_q      <= 1'b1;
                            ready_q     <= 1'b1;
                            busy_q      <= 1'b0;
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
    assign ready       = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_mod_div_seq.sv
// tb_mod_div_seq: directed vectors with hand-computed quotient, remainder and latency for mod_div_seq.
module tb_mod_div_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        ready, busy, done, div_by_zero;
    logic [31:0] quotient, remainder;
    int          n_cmp = 0;
    int          n_err = 0;
    int          edges, busy_cnt;
`ifdef MOD_DIV_SIGNED_EN
    logic        signed_op = 1'b0;
`endif

    mod_div_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
`ifdef MOD_DIV_SIGNED_EN
        .signed_op(signed_op),
`endif
        .start(start), .A(A), .B(B), .ready(ready), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Counts edges from the accepting edge (counted as 1) up to the one that raises done.
    task automatic wait_done(output int e, output int bc);
        e  = 1;
        bc = 0;
        while (!done && e < 60) begin
            if (busy) bc++;
            @(negedge clk);
            e++;
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, output int e, output int bc);
        @(negedge clk);
        A     = a;
        B     = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A     = 32'hDEAD_BEEF;
        B     = 32'h0000_0003;
        wait_done(e, bc);
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input int elat);
        do_op(a, b, edges, busy_cnt);
        check({tag, "_lat"}, edges, elat);
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, elat == 1});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_q", quotient, 32'd0);
        check("rst_r", remainder, 32'd0);
        check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
        reset = 1'b1;

        run("d17_5", 32'd17, 32'd5, 32'd3, 32'd2, 33);
        check("d17_5_busy", busy_cnt, 32);
        check("d17_5_ready", {31'b0, ready}, 32'd1);
        @(negedge clk);
        check("d17_5_pulse", {31'b0, done}, 32'd0);
        repeat (3) @(negedge clk);
        check("d17_5_hold", quotient, 32'd3);

        run("dmax_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33);
        run("dmax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 33);
        run("d3_10", 32'd3, 32'd10, 32'd0, 32'd3, 33);
        run("dz", 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1);
        check("dz_busy", busy_cnt, 0);

        @(negedge clk);
        A = 32'd100;
        B = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_dbz_clr", {31'b0, div_by_zero}, 32'd0);
        repeat (8) @(negedge clk);
        A = 32'd9;
        B = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = 32'd55;
        B = 32'd2;
        edges = 10;
        wait_done(edges, busy_cnt);
        edges += 9;
        check("b2b1_lat", edges, 33);
        check("b2b1_q", quotient, 32'd14);
        check("b2b1_r", remainder, 32'd2);
        A = 32'd9;
        B = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = 32'd0;
        B = 32'd0;
        wait_done(edges, busy_cnt);
        check("b2b2_lat", edges, 33);
        check("b2b2_q", quotient, 32'd3);
        check("b2b2_r", remainder, 32'd0);

        @(negedge clk);
        A = 32'd50;
        B = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_q", quotient, 32'd0);
        check("arst_r", remainder, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_ready", {31'b0, ready}, 32'd1);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i == 0 || done) check("arst_nodone", {31'b0, done}, 32'd0);
        end
        reset = 1'b1;
        run("d8_2", 32'd8, 32'd2, 32'd4, 32'd0, 33);

`ifdef MOD_DIV_SIGNED_EN
        signed_op = 1'b1;
        run("s_m7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        run("s_7_m2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
        run("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
        run("s_m5_0", 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1);
        signed_op = 1'b0;
        run("u_m7_2", 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 33);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mod_div_seq.md
Name: mod_div_seq

Overview:
Parametrised sequential integer divider producing quotient and remainder with a start/done handshake. It supersedes the fixed 32-bit repeated-subtraction modulo unit. It uses a restoring shift-subtract algorithm, one quotient bit per clock, so latency is bounded and independent of operand values. The block sits beside the ALU and is issued by the processor control unit for div/divu/rem/remu-style operations.

Parameters:
WIDTH, 32, operand/result bit width (>=2)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  request; sampled on rising clk edge, accepted only when ready
A  input  WIDTH  dividend; latched on accepted start
B  input  WIDTH  divisor; latched on accepted start
ready  output  1  high in IDLE and DONE; start is accepted only when ready=1
busy  output  1  high in CALC
done  output  1  single-cycle pulse when results become valid
quotient  output  WIDTH  A / B; held until the next accepted start
remainder  output  WIDTH  A mod B; held until the next accepted start
div_by_zero  output  1  set with done when B == 0; held with results

Behaviour:
- Reset (reset=0, async): state=IDLE; quotient=0, remainder=0, done=0, busy=0, div_by_zero=0, ready=1; internal counter and registers cleared. Reset mid-CALC aborts the operation and produces no done.
- States: IDLE, CALC, DONE.
- IDLE: start=1 at an edge -> latch A,B; counter=WIDTH; working rem=0; working quo=A. If B==0, go to DONE; otherwise go to CALC.
- CALC, each edge: {rem,quo} shifted left 1; if shifted rem >= B (unsigned, compared at WIDTH+1 bits), rem -= B and quo[0]=1, else quo[0]=0; counter decrements. When counter reaches 1 on this edge, go to DONE and load quotient/remainder outputs.
- DONE: done=1 for exactly this cycle. start=1 -> accept the new operation as in IDLE (back-to-back issue). Otherwise -> IDLE.
- Latency: normal case, done is high in the cycle after WIDTH+1 edges from the accepting edge (33 edges for WIDTH=32). B==0: done is high after 1 edge.
- Divide by zero: quotient = all ones, remainder = A, div_by_zero=1. No CALC cycles.
- A < B: quotient=0, remainder=A, full latency (no early exit).
- start while busy: ignored. Operands are not re-latched and the counter is not affected.
- Outputs change only on the DONE-entry edge. div_by_zero clears on the next accepted start.
- A and B may change freely after acceptance.

Optional Feature:
MOD_DIV_SIGNED_EN. When defined, add input port signed_op (1 bit, latched with start).
- signed_op=1: A and B are treated as two's complement. Magnitudes are divided by the same datapath. Quotient is negated if sign(A)^sign(B). Remainder takes the sign of A (truncating division).
- Negation is combinational at latch and at result load, so latency is unchanged.
- MIN / -1 gives quotient=MIN, remainder=0, no flag.
- Signed divide by zero gives quotient=all ones (-1), remainder=A.
- signed_op=0, or macro undefined: unsigned only and port absent; behaviour is exactly as above.

Test Plan:
- WIDTH=32, A=17, B=5, start 1 cycle -> busy for 32 cycles; done pulse at edge 33; quotient=3, remainder=2, div_by_zero=0; outputs held afterward.
- A=0xFFFFFFFF, B=1 -> quotient=0xFFFFFFFF, remainder=0. Then A=0xFFFFFFFF, B=0xFFFFFFFF -> quotient=1, remainder=0.
- A=3, B=10 -> quotient=0, remainder=3, latency still 33 edges. A=1234, B=0 -> done after 1 edge, quotient=0xFFFFFFFF, remainder=1234, div_by_zero=1.
- Issue 100/7. Pulse start with 9/3 at cycle 10 (ignored). Then assert start in the DONE cycle with 9/3 -> first result q=14, r=2; second result q=3, r=0, done 33 edges later.
- Drive reset=0 asynchronously at cycle 15 of an operation -> all outputs immediately 0, state IDLE, no done. Release reset, issue 8/2 -> q=4, r=0.
- MOD_DIV_SIGNED_EN, signed_op=1 cases:
  - -7/2 -> q=-3, r=-1.
  - 7/-2 -> q=-3, r=1.
  - 0x80000000/-1 -> q=0x80000000, r=0.
  - With signed_op=0, 0xFFFFFFF9/2 -> q=0x7FFFFFFC, r=1.
